// File: rtl/dm_access_unit_pkg.sv
// Shared encodings and default widths for the data-memory access unit.
package dm_access_unit_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE   = 2'd0,
    DMA_ACCESS = 2'd1,
    DMA_RESP   = 2'd2
  } dma_state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam int DM_ADDR_W = 8;
  localparam int DM_DATA_W = 16;

endpackage

// File: rtl/dm_access_unit.sv
// Initiator side of the data-memory port: one request at a time, one-cycle DM access, held response.
// Optional address range check enabled by defining DM_BOUNDS_CHECK_EN.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int DM_DEPTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_dout
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DM_DEPTH);

  dma_state_t        state_reg, state_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic              in_range;
  logic              accept;

`ifdef DM_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, addr_reg} < DEPTH_LIM);
`else
  // Range result is deliberately ignored: every address reaches the DM.
  assign in_range = 1'b1 | ({1'b0, addr_reg} < DEPTH_LIM);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= DMA_IDLE;
      we_reg    <= OP_LOAD;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    dm_addr    = '0;
    dm_din     = '0;
    dm_we      = 1'b0;
    accept     = 1'b0;

    case (state_reg)
      DMA_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
      end
      DMA_ACCESS: begin
        // Out-of-range accesses keep the DM untouched but still spend the access cycle.
        if (in_range) begin
          dm_addr = addr_reg;
          if (we_reg == OP_STORE) begin
            dm_we  = 1'b1;
            dm_din = wdata_reg;
          end
        end
        rdata_next = (in_range && (we_reg == OP_LOAD)) ? dm_dout : '0;
        err_next   = !in_range;
        state_next = DMA_RESP;
      end
      DMA_RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) begin
          accept     = req_valid;
          state_next = DMA_IDLE;
        end
      end
      default: state_next = DMA_IDLE;
    endcase

    if (accept) begin
      we_next    = req_we;
      addr_next  = req_addr;
      wdata_next = req_wdata;
      state_next = DMA_ACCESS;
    end

    // The state register already sits in IDLE while reset is held; refuse requests until release.
    if (reset) begin
      req_ready = 1'b0;
    end
  end

  assign rsp_rdata = rdata_reg;
`ifdef DM_BOUNDS_CHECK_EN
  assign rsp_err = err_reg;
`else
  assign rsp_err = 1'b0 & err_reg;
`endif

endmodule
